// File: rtl/riscv_pkg.sv
// Shared RISC-V types and constants used by the fetch-side branch predictor.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_counter_e;

  localparam logic [XLEN-1:0] BP_PC_STEP = 32'd4;

  // Tag is kept XLEN wide so the struct does not depend on the BTB depth.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
    logic            is_jump;
  } btb_entry_t;

  function automatic bp_counter_e bp_counter_next(input bp_counter_e cnt, input logic taken);
    bp_counter_e nxt;
    case (cnt)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational read port, one write port.
module bp_btb
  import riscv_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_hit,
  output logic [XLEN-1:0] rd_target,
  output logic            rd_is_jump,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_target,
  input  logic            wr_is_jump
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t      entry_reg [ENTRIES];
  btb_entry_t      rd_entry;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [XLEN-1:0]  rd_tag;
  logic [XLEN-1:0]  wr_tag;

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign rd_tag = rd_pc >> (IDX_W + 2);
  assign wr_tag = wr_pc >> (IDX_W + 2);

  assign rd_entry   = entry_reg[rd_idx];
  assign rd_hit     = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign rd_target  = rd_entry.target;
  assign rd_is_jump = rd_entry.is_jump;

  // Collisions simply overwrite: the last writer owns the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_reg[i] <= '0;
      end
    end else if (wr_en) begin
      entry_reg[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, is_jump: wr_is_jump};
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side predictor: bimodal 2-bit BHT plus direct-mapped BTB, trained at resolve.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor
  import riscv_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  opcode_e         upd_opcode,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int BHT_W = $clog2(BHT_ENTRIES);

  bp_counter_e      bht_reg [BHT_ENTRIES];
  bp_counter_e      pred_cnt;
  logic [BHT_W-1:0] pred_bi;
  logic [BHT_W-1:0] upd_bi;
  logic             upd_branch;
  logic             upd_jump;
  logic             upd_legal;
  logic             btb_hit;
  logic [XLEN-1:0]  btb_target;
  logic             btb_is_jump;

  assign upd_branch = upd_valid && (upd_opcode == OP_BRANCH);
  assign upd_jump   = upd_valid && ((upd_opcode == OP_JAL) || (upd_opcode == OP_JALR));
  assign upd_legal  = upd_branch || upd_jump;

`ifdef BP_GSHARE_EN
  logic [BHT_W-1:0] ghr_reg;

  assign pred_bi = pred_pc[BHT_W+1:2] ^ ghr_reg;
  assign upd_bi  = upd_pc[BHT_W+1:2] ^ ghr_reg;

  // History advances only on resolved branches, never speculatively.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_reg <= '0;
    end else if (upd_branch) begin
      ghr_reg <= BHT_W'({ghr_reg, upd_taken});
    end
  end
`else
  assign pred_bi = pred_pc[BHT_W+1:2];
  assign upd_bi  = upd_pc[BHT_W+1:2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_reg[i] <= WNT;
      end
    end else if (upd_branch) begin
      bht_reg[upd_bi] <= bp_counter_next(bht_reg[upd_bi], upd_taken);
    end
  end

  bp_btb #(
    .ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_pc      (pred_pc),
    .rd_hit     (btb_hit),
    .rd_target  (btb_target),
    .rd_is_jump (btb_is_jump),
    .wr_en      (upd_jump || (upd_branch && upd_taken)),
    .wr_pc      (upd_pc),
    .wr_target  (upd_target),
    .wr_is_jump (upd_jump)
  );

  // Lookups read current table state, so a same-cycle update is not visible yet.
  assign pred_cnt    = bht_reg[pred_bi];
  assign pred_taken  = btb_hit && (btb_is_jump || (pred_cnt == WT) || (pred_cnt == ST));
  assign pred_target = pred_taken ? btb_target : '0;

  assign mispredict  = upd_legal &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : (upd_pc + BP_PC_STEP);

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic vs a reference model.
module tb_branch_predictor;
  import riscv_pkg::*;

  localparam int BHT_N = 64;
  localparam int BTB_N = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     pred_pc;
  logic            pred_taken;
  logic [31:0]     pred_target;
  logic            upd_valid;
  opcode_e         upd_opcode;
  logic [31:0]     upd_pc;
  logic            upd_taken;
  logic [31:0]     upd_target;
  logic            upd_pred_taken;
  logic [31:0]     upd_pred_target;
  logic            mispredict;
  logic [31:0]     redirect_pc;

  always #5 clk = ~clk;

  branch_predictor #(
    .BHT_ENTRIES(BHT_N),
    .BTB_ENTRIES(BTB_N)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pred_pc         (pred_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_opcode      (upd_opcode),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_cycle  = 0;

  // Reference state: counters as plain integers 0..3, BTB slots remember the full writer PC.
  int          m_cnt   [BHT_N];
  bit          m_valid [BTB_N];
  logic [31:0] m_pc    [BTB_N];
  logic [31:0] m_tgt   [BTB_N];
  bit          m_jump  [BTB_N];
  int          m_ghr;

  logic        last_pt;
  logic [31:0] last_ptgt;
  logic        last_mis;
  logic [31:0] last_redir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < BHT_N; i++) m_cnt[i] = 1;
    for (int i = 0; i < BTB_N; i++) begin
      m_valid[i] = 0; m_pc[i] = '0; m_tgt[i] = '0; m_jump[i] = 0;
    end
    m_ghr = 0;
  endtask

  function automatic int bidx(input logic [31:0] pc);
    int b;
    b = int'((pc / 4) % BHT_N);
`ifdef BP_GSHARE_EN
    b = b ^ m_ghr;
`endif
    return b;
  endfunction

  function automatic int tidx(input logic [31:0] pc);
    return int'((pc / 4) % BTB_N);
  endfunction

  function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
    return (a / (4 * BTB_N)) == (b / (4 * BTB_N));
  endfunction

  task automatic model_predict(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
    int  t;
    bit  hit;
    t   = tidx(pc);
    hit = m_valid[t] && same_tag(m_pc[t], pc);
    tk  = hit && (m_jump[t] || m_cnt[bidx(pc)] >= 2);
    tg  = tk ? m_tgt[t] : 32'h0;
  endtask

  task automatic model_btb_write(input logic [31:0] pc, input logic [31:0] tgt, input bit jmp);
    int t;
    t = tidx(pc);
    m_valid[t] = 1; m_pc[t] = pc; m_tgt[t] = tgt; m_jump[t] = jmp;
  endtask

  task automatic model_train(input bit v, input opcode_e op, input logic [31:0] pc,
                             input bit tk, input logic [31:0] tgt);
    int b;
    if (!v) return;
    if (op == OP_BRANCH) begin
      b = bidx(pc);
      if (tk) m_cnt[b] = (m_cnt[b] == 3) ? 3 : m_cnt[b] + 1;
      else    m_cnt[b] = (m_cnt[b] == 0) ? 0 : m_cnt[b] - 1;
      if (tk) model_btb_write(pc, tgt, 0);
      m_ghr = ((m_ghr * 2) + int'(tk)) % BHT_N;
    end else if (op == OP_JAL || op == OP_JALR) begin
      model_btb_write(pc, tgt, 1);
    end
  endtask

  // One clock of traffic: drive, check combinational outputs, then train the model at the edge.
  task automatic cycle(input string name, input logic [31:0] lpc, input bit v, input opcode_e op,
                       input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                       input bit ptk, input logic [31:0] ptgt);
    bit          etk;
    logic [31:0] etg;
    bit          legal;
    bit          emis;
    logic [31:0] eredir;
    pred_pc = lpc; upd_valid = v; upd_opcode = op; upd_pc = pc;
    upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    #1;
    model_predict(lpc, etk, etg);
    legal  = v && (op == OP_BRANCH || op == OP_JAL || op == OP_JALR);
    emis   = legal && ((tk != ptk) || (tk && tgt != ptgt));
    eredir = tk ? tgt : pc + 32'd4;
    last_pt = pred_taken; last_ptgt = pred_target; last_mis = mispredict; last_redir = redirect_pc;
    check({name, ".pred_taken"},  32'(pred_taken), 32'(etk));
    check({name, ".pred_target"}, pred_target,     etg);
    check({name, ".mispredict"},  32'(mispredict), 32'(emis));
    if (emis) check({name, ".redirect_pc"}, redirect_pc, eredir);
    $display("cyc %0d %s lookup=%08h pt=%0d ptgt=%08h | upd v=%0d op=%s pc=%08h tk=%0d tgt=%08h mis=%0d redir=%08h",
             n_cycle, name, lpc, pred_taken, pred_target, v, op.name(), pc, tk, tgt, mispredict, redirect_pc);
    n_cycle++;
    @(posedge clk);
    if (rst_n) model_train(v, op, pc, tk, tgt);
    @(negedge clk);
  endtask

  task automatic lookup(input string name, input logic [31:0] lpc);
    cycle(name, lpc, 0, OP_BRANCH, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  logic [31:0] tgt_pool [4] = '{32'h0000_8000, 32'h0000_1100, 32'h0000_5100, 32'hFFFF_FFF0};

  initial begin
    rst_n = 1'b0;
    pred_pc = '0; upd_valid = 0; upd_opcode = OP_BRANCH; upd_pc = '0;
    upd_taken = 0; upd_target = '0; upd_pred_taken = 0; upd_pred_target = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    lookup("reset_lookup", 32'h1000);
    check("reset_pt_const", 32'(last_pt), 32'd0);

    cycle("beq_taken", 32'h1000, 1, OP_BRANCH, 32'h1000, 1, 32'h1100, 0, 32'h0);
    check("beq_mis_const", 32'(last_mis), 32'd1);
    check("beq_redir_const", last_redir, 32'h1100);
    lookup("beq_lookup", 32'h1000);
    check("beq_pt_const", 32'(last_pt), 32'd1);
    check("beq_ptgt_const", last_ptgt, 32'h1100);

    for (int i = 0; i < 4; i++) begin
      cycle("beq_nt", 32'h1000, 1, OP_BRANCH, 32'h1000, 0, 32'h1100, 1, 32'h1100);
      check("beq_nt_redir_const", last_redir, 32'h1004);
    end
    lookup("beq_nt_lookup", 32'h1000);
    check("beq_nt_pt_const", 32'(last_pt), 32'd0);
    // From a saturated SNT, one taken only reaches WNT: still predicted not-taken.
    cycle("beq_sat", 32'h1000, 1, OP_BRANCH, 32'h1000, 1, 32'h1100, 0, 32'h0);
    lookup("beq_sat_lookup", 32'h1000);
    check("beq_sat_pt_const", 32'(last_pt), 32'd0);

    cycle("jalr", 32'h2000, 1, OP_JALR, 32'h2000, 1, 32'h5100, 1, 32'h5000);
    check("jalr_mis_const", 32'(last_mis), 32'd1);
    check("jalr_redir_const", last_redir, 32'h5100);
    lookup("jalr_lookup", 32'h2000);
    check("jalr_pt_const", 32'(last_pt), 32'd1);
    check("jalr_ptgt_const", last_ptgt, 32'h5100);

    cycle("alias_train", 32'h1000, 1, OP_BRANCH, 32'h1000, 1, 32'h1100, 0, 32'h0);
    lookup("alias_pre", 32'h1000);
    check("alias_pre_const", 32'(last_pt), 32'd1);
    cycle("alias_jal", 32'h1000, 1, OP_JAL, 32'h1040, 1, 32'h9000, 0, 32'h0);
    lookup("alias_post", 32'h1000);
    check("alias_post_const", 32'(last_pt), 32'd0);

    cycle("readold", 32'h3000, 1, OP_JAL, 32'h3000, 1, 32'h3300, 0, 32'h0);
    check("readold_same_const", 32'(last_pt), 32'd0);
    lookup("readold_next", 32'h3000);
    check("readold_next_const", 32'(last_pt), 32'd1);

    cycle("illegal_op", 32'h4000, 1, OP_LOAD, 32'h4000, 1, 32'h4400, 0, 32'h0);
    check("illegal_mis_const", 32'(last_mis), 32'd0);
    lookup("illegal_lookup", 32'h4000);
    check("illegal_pt_const", 32'(last_pt), 32'd0);

    cycle("wrap", 32'h0, 1, OP_BRANCH, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10);
    check("wrap_redir_const", last_redir, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] lpc, upc, tgt, ptgt;
      bit          v, tk, ptk, mtk;
      logic [31:0] mtg;
      opcode_e     op;
      int          sel;
      lpc = 32'h1000 + 4 * $urandom_range(0, 127);
      upc = 32'h1000 + 4 * $urandom_range(0, 127);
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      op  = (sel < 6) ? OP_BRANCH : (sel < 8) ? OP_JAL : (sel < 9) ? OP_JALR : OP_OP;
      tk  = (op == OP_JAL || op == OP_JALR) ? 1'b1 : 1'($urandom_range(0, 1));
      tgt = tgt_pool[$urandom_range(0, 3)] + 4 * $urandom_range(0, 3);
      if ($urandom_range(0, 1) != 0) begin
        model_predict(upc, mtk, mtg);
        ptk = mtk; ptgt = mtg;
      end else begin
        ptk = 1'($urandom_range(0, 1)); ptgt = tgt_pool[$urandom_range(0, 3)];
      end
      cycle("rand", lpc, v, op, upc, tk, tgt, ptk, ptgt);
    end

    cycle("pre_rst_train", 32'h6000, 1, OP_JAL, 32'h6000, 1, 32'h6600, 0, 32'h0);
    lookup("pre_rst_lookup", 32'h6000);
    check("pre_rst_pt_const", 32'(last_pt), 32'd1);

    // Reset lands mid-cycle with an update on the bus; it must clear at once and drop the update.
    pred_pc = 32'h6000; upd_valid = 1; upd_opcode = OP_JAL; upd_pc = 32'h7000;
    upd_taken = 1; upd_target = 32'h7700; upd_pred_taken = 0; upd_pred_target = '0;
    #2 rst_n = 1'b0;
    #1 check("async_rst_pt", 32'(pred_taken), 32'd0);
    check("async_rst_ptgt", pred_target, 32'h0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lookup("post_rst_7000", 32'h7000);
    check("post_rst_7000_const", 32'(last_pt), 32'd0);
    lookup("post_rst_6000", 32'h6000);
    check("post_rst_6000_const", 32'(last_pt), 32'd0);
    lookup("post_rst_2000", 32'h2000);
    check("post_rst_2000_const", 32'(last_pt), 32'd0);
    lookup("post_rst_3000", 32'h3000);
    check("post_rst_3000_const", 32'(last_pt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
